// File: rtl/adc_interface_mc_if.sv
// Simple Interface (rdy/ack) carrying one packed multi-channel ADC word.
interface adc_interface_mc_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] SI_data;
    logic             SI_rdy;
    logic             SI_ack;

    modport master (output SI_data, output SI_rdy, input SI_ack);
    modport slave  (input SI_data, input SI_rdy, output SI_ack);
endinterface

// File: rtl/adc_interface_mc.sv
// Multi-channel parallel ADC front end: programmable shared ADC clock, rdy/ack
// delivery, peak-hold of samples arriving while the consumer stalls.
module adc_interface_mc #(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNELS      = 2,
    parameter int CLK_DIV_WIDTH = 32,
    parameter int OVR_WIDTH     = 16
) (
    input  logic                           clk_i,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ADC_data,
    output logic                           ADC_oe,
    output logic                           clk_o,
    adc_interface_mc_if.master             si,
    input  logic [CLK_DIV_WIDTH-1:0]       decimation_factor,
    input  logic                           enable_i,
    input  logic [1:0]                     mode_i,
    input  logic                           overrun_clr_i,
    output logic [OVR_WIDTH-1:0]           overrun_cnt_o
);
    localparam int WORD_W = CHANNELS * DATA_WIDTH;

    typedef enum logic [1:0] {
        MODE_PLAIN = 2'd0,
        MODE_MAX   = 2'd1,
        MODE_MIN   = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    logic [CLK_DIV_WIDTH-1:0] counter;
    logic [CLK_DIV_WIDTH-1:0] counter_next;
    logic [CLK_DIV_WIDTH:0]   half_period;
    logic                     clk_o_div;
    logic                     bypass;
    logic                     strobe;
    logic                     accept;
    logic                     plain;
    mode_e                    mode_cur;
    mode_e                    mode_r;
    logic [WORD_W-1:0]        acc;
    logic [WORD_W-1:0]        sel;
    logic                     acc_v;
    logic                     acc_v_eff;

    assign ADC_oe      = 1'b0;
    assign bypass      = (decimation_factor == '0);
    assign half_period = ({1'b0, decimation_factor} + (CLK_DIV_WIDTH+1)'(1)) >> 1;
    assign strobe      = enable_i && (bypass || counter == decimation_factor);
    assign accept      = !si.SI_rdy || si.SI_ack;
    assign mode_cur    = mode_e'(mode_i);
    assign plain       = (mode_cur == MODE_PLAIN) || (mode_cur == MODE_RSVD);
    // A mode switch invalidates the held extreme in the same cycle it is seen.
    assign acc_v_eff   = acc_v && (mode_cur == mode_r);

    // Divide-by-1 bypass is the single combinational path from clk_i to clk_o.
    assign clk_o = bypass ? clk_i : clk_o_div;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        counter_next = counter + CLK_DIV_WIDTH'(1);
        if (!enable_i || counter >= decimation_factor) begin
            counter_next = '0;
        end
    end

    always_comb begin
        sel = ADC_data;
        for (int k = 0; k < CHANNELS; k++) begin
            if (acc_v_eff) begin
                if (mode_cur == MODE_MAX) begin
                    if (acc[k*DATA_WIDTH +: DATA_WIDTH] > ADC_data[k*DATA_WIDTH +: DATA_WIDTH])
                        sel[k*DATA_WIDTH +: DATA_WIDTH] = acc[k*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    if (acc[k*DATA_WIDTH +: DATA_WIDTH] < ADC_data[k*DATA_WIDTH +: DATA_WIDTH])
                        sel[k*DATA_WIDTH +: DATA_WIDTH] = acc[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            counter       <= '0;
            clk_o_div     <= 1'b0;
            mode_r        <= MODE_PLAIN;
            acc           <= '0;
            acc_v         <= 1'b0;
            si.SI_rdy     <= 1'b0;
            si.SI_data    <= '0;
            overrun_cnt_o <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            counter   <= counter_next;
            clk_o_div <= enable_i && ({1'b0, counter_next} < half_period);
            mode_r    <= mode_cur;

            if (mode_cur != mode_r) acc_v <= 1'b0;

            if (strobe && accept) begin
                si.SI_rdy  <= 1'b1;
                si.SI_data <= plain ? ADC_data : sel;
                if (!plain) acc_v <= 1'b0;
            end else if (strobe) begin
                if (!plain) begin
                    acc   <= sel;
                    acc_v <= 1'b1;
                end
            end else if (si.SI_rdy && si.SI_ack) begin
                si.SI_rdy <= 1'b0;
            end

            if (overrun_clr_i) begin
                overrun_cnt_o <= '0;
            end else if (strobe && !accept && plain && overrun_cnt_o != '1) begin
                overrun_cnt_o <= overrun_cnt_o + OVR_WIDTH'(1);
            end
        end
    end
endmodule
